// File: rtl/ctrl_pipe.sv
// rtl/ctrl_pipe.sv - ID/EX, EX/MEM, MEM/WB control pipeline with load-use stall and flush generation
//
// Purpose:
//   Receives the opcode decoder's control word and register fields for the
//   instruction in ID. Carries them through the ID/EX, EX/MEM and MEM/WB
//   registers. Generates the PC and IF/ID enables and the IF/ID flush, so that
//   downstream stages see all-zero bubbles where the pipeline requires them.
//
// Ports:
//   clk, reset                    - rising-edge clock, synchronous active-high reset
//   id_*                          - decoder controls and register fields for the ID instruction
//   branch_taken                  - branch in MEM resolved taken
//   pc_write, ifid_write          - PC and IF/ID enables; low while a load-use stall is held
//   ifid_flush                    - zero IF/ID on the next edge (jump in ID or taken branch)
//   ex_*                          - ID/EX register outputs
//   mem_*                         - EX/MEM register outputs
//   wb_*                          - MEM/WB register outputs
module ctrl_pipe #(
    parameter int REG_W    = 5,
    parameter int ALUOP_W  = 5,
    parameter int LINK_REG = 31
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               id_Jump,
    input  logic               id_Jal,
    input  logic               id_Branch,
    input  logic               id_MemRead,
    input  logic               id_MemWrite,
    input  logic               id_MemtoReg,
    input  logic               id_RegSrc,
    input  logic               id_RegDst,
    input  logic               id_RegWrite,
    input  logic               id_PCSrc,
    input  logic               id_ALUSrc,
    input  logic [ALUOP_W-1:0] id_AluOp,
    input  logic [REG_W-1:0]   id_rs,
    input  logic [REG_W-1:0]   id_rt,
    input  logic [REG_W-1:0]   id_rd,
    input  logic               branch_taken,
    output logic               pc_write,
    output logic               ifid_write,
    output logic               ifid_flush,
    output logic               ex_RegDst,
    output logic               ex_ALUSrc,
    output logic               ex_RegSrc,
    output logic               ex_PCSrc,
    output logic [ALUOP_W-1:0] ex_AluOp,
    output logic [REG_W-1:0]   ex_rs,
    output logic [REG_W-1:0]   ex_rt,
    output logic [REG_W-1:0]   ex_dst,
    output logic               mem_Branch,
    output logic               mem_MemRead,
    output logic               mem_MemWrite,
    output logic [REG_W-1:0]   mem_dst,
    output logic               mem_RegWrite,
    output logic               wb_MemtoReg,
    output logic               wb_RegWrite,
    output logic               wb_Jal,
    output logic [REG_W-1:0]   wb_dst
);

    // ID/EX register
    logic               r_ex_RegDst;
    logic               r_ex_ALUSrc;
    logic               r_ex_RegSrc;
    logic               r_ex_PCSrc;
    logic               r_ex_Branch;
    logic               r_ex_MemRead;
    logic               r_ex_MemWrite;
    logic               r_ex_MemtoReg;
    logic               r_ex_RegWrite;
    logic               r_ex_Jal;
    logic [ALUOP_W-1:0] r_ex_AluOp;
    logic [REG_W-1:0]   r_ex_rs;
    logic [REG_W-1:0]   r_ex_rt;
    logic [REG_W-1:0]   r_ex_dst;

    // EX/MEM register
    logic               r_mem_Branch;
    logic               r_mem_MemRead;
    logic               r_mem_MemWrite;
    logic               r_mem_MemtoReg;
    logic               r_mem_RegWrite;
    logic               r_mem_Jal;
    logic [REG_W-1:0]   r_mem_dst;

    // MEM/WB register
    logic               r_wb_MemtoReg;
    logic               r_wb_RegWrite;
    logic               r_wb_Jal;
    logic [REG_W-1:0]   r_wb_dst;

    logic               w_load_use;
    logic               w_stall;
    logic               w_idex_bubble;
    logic [REG_W-1:0]   w_id_dst;

    // Link writes go to the fixed link register regardless of RegDst.
    assign w_id_dst = id_RegSrc ? REG_W'(LINK_REG) :
                      id_RegDst ? id_rd : id_rt;

    // A load in EX whose destination is read by the ID instruction. Register 0
    // is never a real dependency.
    assign w_load_use = r_ex_MemRead &&
                        ((r_ex_dst == id_rs) || (r_ex_dst == id_rt)) &&
                        (r_ex_dst != '0);

    // A taken branch squashes the dependent instruction, so the stall is moot.
    assign w_stall       = w_load_use && !branch_taken;
    assign w_idex_bubble = w_stall || branch_taken;

    // While reset is held the front end is left free-running and unflushed.
    assign pc_write   = reset || !w_stall;
    assign ifid_write = reset || !w_stall;
    assign ifid_flush = !reset &&
                        (branch_taken || ((id_Jump || id_PCSrc) && !w_stall));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ex_RegDst    <= 1'b0;
            r_ex_ALUSrc    <= 1'b0;
            r_ex_RegSrc    <= 1'b0;
            r_ex_PCSrc     <= 1'b0;
            r_ex_Branch    <= 1'b0;
            r_ex_MemRead   <= 1'b0;
            r_ex_MemWrite  <= 1'b0;
            r_ex_MemtoReg  <= 1'b0;
            r_ex_RegWrite  <= 1'b0;
            r_ex_Jal       <= 1'b0;
            r_ex_AluOp     <= '0;
            r_ex_rs        <= '0;
            r_ex_rt        <= '0;
            r_ex_dst       <= '0;
            r_mem_Branch   <= 1'b0;
            r_mem_MemRead  <= 1'b0;
            r_mem_MemWrite <= 1'b0;
            r_mem_MemtoReg <= 1'b0;
            r_mem_RegWrite <= 1'b0;
            r_mem_Jal      <= 1'b0;
            r_mem_dst      <= '0;
            r_wb_MemtoReg  <= 1'b0;
            r_wb_RegWrite  <= 1'b0;
            r_wb_Jal       <= 1'b0;
            r_wb_dst       <= '0;
        end else begin
            if (w_idex_bubble) begin
                r_ex_RegDst   <= 1'b0;
                r_ex_ALUSrc   <= 1'b0;
                r_ex_RegSrc   <= 1'b0;
                r_ex_PCSrc    <= 1'b0;
                r_ex_Branch   <= 1'b0;
                r_ex_MemRead  <= 1'b0;
                r_ex_MemWrite <= 1'b0;
                r_ex_MemtoReg <= 1'b0;
                r_ex_RegWrite <= 1'b0;
                r_ex_Jal      <= 1'b0;
                r_ex_AluOp    <= '0;
                r_ex_rs       <= '0;
                r_ex_rt       <= '0;
                r_ex_dst      <= '0;
            end else begin
                r_ex_RegDst   <= id_RegDst;
                r_ex_ALUSrc   <= id_ALUSrc;
                r_ex_RegSrc   <= id_RegSrc;
                r_ex_PCSrc    <= id_PCSrc;
                r_ex_Branch   <= id_Branch;
                r_ex_MemRead  <= id_MemRead;
                r_ex_MemWrite <= id_MemWrite;
                r_ex_MemtoReg <= id_MemtoReg;
                r_ex_RegWrite <= id_RegWrite;
                r_ex_Jal      <= id_Jal;
                r_ex_AluOp    <= id_AluOp;
                r_ex_rs       <= id_rs;
                r_ex_rt       <= id_rt;
                r_ex_dst      <= w_id_dst;
            end

            // The instruction in EX is on the wrong path when a branch in MEM is taken.
            if (branch_taken) begin
                r_mem_Branch   <= 1'b0;
                r_mem_MemRead  <= 1'b0;
                r_mem_MemWrite <= 1'b0;
                r_mem_MemtoReg <= 1'b0;
                r_mem_RegWrite <= 1'b0;
                r_mem_Jal      <= 1'b0;
                r_mem_dst      <= '0;
            end else begin
                r_mem_Branch   <= r_ex_Branch;
                r_mem_MemRead  <= r_ex_MemRead;
                r_mem_MemWrite <= r_ex_MemWrite;
                r_mem_MemtoReg <= r_ex_MemtoReg;
                r_mem_RegWrite <= r_ex_RegWrite;
                r_mem_Jal      <= r_ex_Jal;
                r_mem_dst      <= r_ex_dst;
            end

            // The branch itself completes, so MEM/WB always advances.
            r_wb_MemtoReg <= r_mem_MemtoReg;
            r_wb_RegWrite <= r_mem_RegWrite;
            r_wb_Jal      <= r_mem_Jal;
            r_wb_dst      <= r_mem_dst;
        end
    end

    assign ex_RegDst    = r_ex_RegDst;
    assign ex_ALUSrc    = r_ex_ALUSrc;
    assign ex_RegSrc    = r_ex_RegSrc;
    assign ex_PCSrc     = r_ex_PCSrc;
    assign ex_AluOp     = r_ex_AluOp;
    assign ex_rs        = r_ex_rs;
    assign ex_rt        = r_ex_rt;
    assign ex_dst       = r_ex_dst;
    assign mem_Branch   = r_mem_Branch;
    assign mem_MemRead  = r_mem_MemRead;
    assign mem_MemWrite = r_mem_MemWrite;
    assign mem_dst      = r_mem_dst;
    assign mem_RegWrite = r_mem_RegWrite;
    assign wb_MemtoReg  = r_wb_MemtoReg;
    assign wb_RegWrite  = r_wb_RegWrite;
    assign wb_Jal       = r_wb_Jal;
    assign wb_dst       = r_wb_dst;

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb/tb_ctrl_pipe.sv - directed self-checking bench for ctrl_pipe
module tb_ctrl_pipe;

    // Control word bit masks: {Jump,Jal,Branch,MemRead,MemWrite,MemtoReg,RegSrc,RegDst,RegWrite,PCSrc,ALUSrc}
    localparam logic [10:0] C_JUMP   = 11'h400;
    localparam logic [10:0] C_JAL    = 11'h200;
    localparam logic [10:0] C_BR     = 11'h100;
    localparam logic [10:0] C_MR     = 11'h080;
    localparam logic [10:0] C_MW     = 11'h040;
    localparam logic [10:0] C_M2R    = 11'h020;
    localparam logic [10:0] C_RSRC   = 11'h010;
    localparam logic [10:0] C_RDST   = 11'h008;
    localparam logic [10:0] C_RW     = 11'h004;
    localparam logic [10:0] C_ALUSRC = 11'h001;

    logic       clk = 1'b0;
    logic       reset;
    logic [10:0] ctl;
    logic [4:0] id_AluOp, id_rs, id_rt, id_rd;
    logic       branch_taken;
    logic       pc_write, ifid_write, ifid_flush;
    logic       ex_RegDst, ex_ALUSrc, ex_RegSrc, ex_PCSrc;
    logic [4:0] ex_AluOp, ex_rs, ex_rt, ex_dst;
    logic       mem_Branch, mem_MemRead, mem_MemWrite, mem_RegWrite;
    logic [4:0] mem_dst;
    logic       wb_MemtoReg, wb_RegWrite, wb_Jal;
    logic [4:0] wb_dst;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ctrl_pipe dut (
        .clk          (clk),
        .reset        (reset),
        .id_Jump      (ctl[10]),
        .id_Jal       (ctl[9]),
        .id_Branch    (ctl[8]),
        .id_MemRead   (ctl[7]),
        .id_MemWrite  (ctl[6]),
        .id_MemtoReg  (ctl[5]),
        .id_RegSrc    (ctl[4]),
        .id_RegDst    (ctl[3]),
        .id_RegWrite  (ctl[2]),
        .id_PCSrc     (ctl[1]),
        .id_ALUSrc    (ctl[0]),
        .id_AluOp     (id_AluOp),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_rd        (id_rd),
        .branch_taken (branch_taken),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .ifid_flush   (ifid_flush),
        .ex_RegDst    (ex_RegDst),
        .ex_ALUSrc    (ex_ALUSrc),
        .ex_RegSrc    (ex_RegSrc),
        .ex_PCSrc     (ex_PCSrc),
        .ex_AluOp     (ex_AluOp),
        .ex_rs        (ex_rs),
        .ex_rt        (ex_rt),
        .ex_dst       (ex_dst),
        .mem_Branch   (mem_Branch),
        .mem_MemRead  (mem_MemRead),
        .mem_MemWrite (mem_MemWrite),
        .mem_dst      (mem_dst),
        .mem_RegWrite (mem_RegWrite),
        .wb_MemtoReg  (wb_MemtoReg),
        .wb_RegWrite  (wb_RegWrite),
        .wb_Jal       (wb_Jal),
        .wb_dst       (wb_dst)
    );

    wire [8:0]  ex_ctl  = {ex_RegDst, ex_ALUSrc, ex_RegSrc, ex_PCSrc, ex_AluOp};
    wire [31:0] all_reg = {ex_ctl, ex_rs, ex_rt, ex_dst[3:0],
                           mem_Branch, mem_MemRead, mem_MemWrite, mem_RegWrite, mem_dst,
                           wb_MemtoReg, wb_RegWrite, wb_Jal};

    task automatic drive(input logic [10:0] c, input logic [4:0] op,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        ctl = c; id_AluOp = op; id_rs = rs; id_rt = rt; id_rd = rd;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        branch_taken = 1'b0;
        drive(11'h7ff, 5'h1f, 5'h11, 5'h12, 5'h13);
        tick();
        tick();
        n_cmp++; if (all_reg !== 32'h0 || ex_dst !== 5'd0 || wb_dst !== 5'd0) begin
            n_bad++; $display("FAIL reset_regs got %h ex_dst %0d wb_dst %0d want 0", all_reg, ex_dst, wb_dst); end
        n_cmp++; if (pc_write !== 1'b1 || ifid_flush !== 1'b0) begin
            n_bad++; $display("FAIL reset_front got pc_write %b flush %b want 1 0", pc_write, ifid_flush); end
        drive(11'h0, 5'd0, 5'd0, 5'd0, 5'd0);
        reset = 1'b0;
        #1;
        n_cmp++; if (pc_write !== 1'b1 || ifid_write !== 1'b1 || ifid_flush !== 1'b0) begin
            n_bad++; $display("FAIL post_reset got %b%b%b want 110", pc_write, ifid_write, ifid_flush); end
    endtask

    task automatic test_rtype;
        drive(C_RDST | C_RW, 5'b00010, 5'd1, 5'd2, 5'd7);
        tick();
        drive(11'h0, 5'd0, 5'd0, 5'd0, 5'd0);
        n_cmp++; if (ex_dst !== 5'd7 || ex_AluOp !== 5'b00010 || ex_RegDst !== 1'b1 || ex_rs !== 5'd1 || ex_rt !== 5'd2) begin
            n_bad++; $display("FAIL rtype_ex got dst %0d op %b rd %b rs %0d rt %0d want 7 00010 1 1 2", ex_dst, ex_AluOp, ex_RegDst, ex_rs, ex_rt); end
        tick();
        n_cmp++; if (mem_dst !== 5'd7 || mem_RegWrite !== 1'b1) begin
            n_bad++; $display("FAIL rtype_mem got dst %0d rw %b want 7 1", mem_dst, mem_RegWrite); end
        tick();
        n_cmp++; if (wb_dst !== 5'd7 || wb_RegWrite !== 1'b1 || wb_MemtoReg !== 1'b0) begin
            n_bad++; $display("FAIL rtype_wb got dst %0d rw %b m2r %b want 7 1 0", wb_dst, wb_RegWrite, wb_MemtoReg); end
    endtask

    task automatic test_load_use;
        drive(C_MR | C_M2R | C_RW | C_ALUSRC, 5'd0, 5'd2, 5'd4, 5'd0);
        tick();
        drive(C_RDST | C_RW, 5'b00010, 5'd4, 5'd5, 5'd6);
        n_cmp++; if (pc_write !== 1'b0 || ifid_write !== 1'b0) begin
            n_bad++; $display("FAIL lu_stall got pc %b ifid %b want 0 0", pc_write, ifid_write); end
        tick();
        n_cmp++; if (ex_ctl !== 9'h0 || mem_MemRead !== 1'b1 || mem_dst !== 5'd4) begin
            n_bad++; $display("FAIL lu_bubble got ex_ctl %h mr %b mdst %0d want 0 1 4", ex_ctl, mem_MemRead, mem_dst); end
        n_cmp++; if (pc_write !== 1'b1 || ifid_write !== 1'b1) begin
            n_bad++; $display("FAIL lu_one_cycle got pc %b ifid %b want 1 1", pc_write, ifid_write); end
        tick();
        n_cmp++; if (ex_dst !== 5'd6 || ex_RegDst !== 1'b1 || ex_rs !== 5'd4) begin
            n_bad++; $display("FAIL lu_add_ex got dst %0d rd %b rs %0d want 6 1 4", ex_dst, ex_RegDst, ex_rs); end
        drive(C_MR | C_M2R | C_RW | C_ALUSRC, 5'd0, 5'd2, 5'd0, 5'd0);
        tick();
        drive(C_RDST | C_RW, 5'b00010, 5'd0, 5'd0, 5'd6);
        n_cmp++; if (pc_write !== 1'b1 || ifid_write !== 1'b1) begin
            n_bad++; $display("FAIL lu_r0 got pc %b ifid %b want 1 1", pc_write, ifid_write); end
        tick();
        drive(11'h0, 5'd0, 5'd0, 5'd0, 5'd0);
        tick();
    endtask

    task automatic test_jal;
        drive(C_JUMP | C_JAL | C_RSRC | C_RW, 5'd0, 5'd0, 5'd3, 5'd0);
        n_cmp++; if (ifid_flush !== 1'b1) begin
            n_bad++; $display("FAIL jal_flush got %b want 1", ifid_flush); end
        tick();
        drive(11'h0, 5'd0, 5'd0, 5'd0, 5'd0);
        n_cmp++; if (ex_dst !== 5'd31 || ex_RegSrc !== 1'b1 || ifid_flush !== 1'b0) begin
            n_bad++; $display("FAIL jal_ex got dst %0d rsrc %b flush %b want 31 1 0", ex_dst, ex_RegSrc, ifid_flush); end
        tick();
        tick();
        n_cmp++; if (wb_Jal !== 1'b1 || wb_dst !== 5'd31) begin
            n_bad++; $display("FAIL jal_wb got jal %b dst %0d want 1 31", wb_Jal, wb_dst); end
        // Jump behind a load it depends on: flush deferred one cycle.
        drive(C_MR | C_RW, 5'd0, 5'd1, 5'd8, 5'd0);
        tick();
        drive(C_JUMP, 5'd0, 5'd8, 5'd0, 5'd0);
        n_cmp++; if (ifid_flush !== 1'b0 || pc_write !== 1'b0) begin
            n_bad++; $display("FAIL jump_stall got flush %b pc %b want 0 0", ifid_flush, pc_write); end
        tick();
        n_cmp++; if (ifid_flush !== 1'b1 || pc_write !== 1'b1) begin
            n_bad++; $display("FAIL jump_retry got flush %b pc %b want 1 1", ifid_flush, pc_write); end
        tick();
        drive(11'h0, 5'd0, 5'd0, 5'd0, 5'd0);
        tick();
    endtask

    task automatic test_branch_stall;
        drive(C_BR, 5'b00001, 5'd1, 5'd2, 5'd0);
        tick();
        drive(C_MR | C_M2R | C_RW | C_ALUSRC, 5'd0, 5'd3, 5'd9, 5'd0);
        tick();
        drive(C_RDST | C_RW, 5'b00010, 5'd9, 5'd5, 5'd10);
        n_cmp++; if (mem_Branch !== 1'b1 || pc_write !== 1'b0) begin
            n_bad++; $display("FAIL br_setup got mb %b pc %b want 1 0", mem_Branch, pc_write); end
        branch_taken = 1'b1;
        #1;
        n_cmp++; if (ifid_flush !== 1'b1 || pc_write !== 1'b1 || ifid_write !== 1'b1) begin
            n_bad++; $display("FAIL br_front got %b%b%b want 111", ifid_flush, pc_write, ifid_write); end
        tick();
        branch_taken = 1'b0;
        drive(11'h0, 5'd0, 5'd0, 5'd0, 5'd0);
        n_cmp++; if (ex_ctl !== 9'h0 || mem_Branch !== 1'b0 || mem_MemRead !== 1'b0 || mem_RegWrite !== 1'b0) begin
            n_bad++; $display("FAIL br_squash got ex_ctl %h mb %b mr %b mrw %b want 0 0 0 0", ex_ctl, mem_Branch, mem_MemRead, mem_RegWrite); end
        tick();
    endtask

    task automatic test_reset_mid;
        drive(C_MW | C_ALUSRC, 5'd0, 5'd1, 5'd3, 5'd0);
        tick();
        drive(11'h0, 5'd0, 5'd0, 5'd0, 5'd0);
        tick();
        n_cmp++; if (mem_MemWrite !== 1'b1) begin
            n_bad++; $display("FAIL sw_mem got %b want 1", mem_MemWrite); end
        reset = 1'b1;
        tick();
        n_cmp++; if (mem_MemWrite !== 1'b0 || all_reg !== 32'h0) begin
            n_bad++; $display("FAIL reset_mid got mw %b regs %h want 0 0", mem_MemWrite, all_reg); end
        reset = 1'b0;
        tick();
        n_cmp++; if (mem_MemWrite !== 1'b0) begin
            n_bad++; $display("FAIL reset_after got %b want 0", mem_MemWrite); end
    endtask

    initial begin
        ctl = '0; id_AluOp = '0; id_rs = '0; id_rt = '0; id_rd = '0;
        reset = 1'b1; branch_taken = 1'b0;
        test_reset();
        test_rtype();
        test_load_use();
        test_jal();
        test_branch_stall();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Consumer end of the decoder's control bundle: registers the ID-stage control word and register fields through ID/EX, EX/MEM and MEM/WB.
- Generates load-use stall and control-hazard flush signals so downstream stages see bubbles (all-zero controls) where required.
- Sits between the opcode decoder and the EX/MEM/WB datapath muxes.

Parameters:
REG_W, 5, register index width
ALUOP_W, 5, AluOp width
LINK_REG, 31, destination index forced when RegSrc=1 (jal/jalr link)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
id_Jump, id_Jal, id_Branch, id_MemRead, id_MemWrite, id_MemtoReg, id_RegSrc, id_RegDst, id_RegWrite, id_PCSrc, id_ALUSrc  in  1 each  decoder controls for the instruction in ID
id_AluOp  in  ALUOP_W  decoder ALU op
id_rs, id_rt, id_rd  in  REG_W each  register fields of the ID instruction
branch_taken  in  1  branch resolved taken in MEM (driven from mem_Branch and ALU zero)
pc_write  out  1  PC enable
ifid_write  out  1  IF/ID enable
ifid_flush  out  1  zero IF/ID on next edge
ex_RegDst, ex_ALUSrc, ex_RegSrc, ex_PCSrc  out  1 each  EX controls
ex_AluOp  out  ALUOP_W  EX ALU op
ex_rs, ex_rt  out  REG_W each  EX operand indices
ex_dst  out  REG_W  EX destination index
mem_Branch, mem_MemRead, mem_MemWrite  out  1 each  MEM controls
mem_dst  out  REG_W  MEM destination
mem_RegWrite  out  1  MEM write-back enable (forwarding)
wb_MemtoReg, wb_RegWrite, wb_Jal  out  1 each  WB controls
wb_dst  out  REG_W  WB destination

Behaviour:
- Reset (sync, active-high): every registered control, index and dst output = 0; pc_write=ifid_write=1, ifid_flush=0 in the cycle after reset deasserts. Reset mid-operation discards all in-flight stages the same edge.
- ID/EX register: on each edge, loads id_* controls, id_AluOp, id_rs, id_rt, and a destination index ex_dst, unless bubbled. ex_dst = LINK_REG if id_RegSrc, else id_rd if id_RegDst, else id_rt.
- EX/MEM: loads mem_Branch, mem_MemRead, mem_MemWrite, mem_RegWrite, mem_dst, plus carried MemtoReg/Jal from ID/EX.
- MEM/WB: loads wb_MemtoReg, wb_RegWrite, wb_Jal, wb_dst from EX/MEM.
- Latency: an ID control word reaches ex_* 1 cycle, mem_* 2 cycles, wb_* 3 cycles after it is presented.
- Bubble = all control bits and AluOp zero; index fields are don't-care but are driven 0.
- Load-use stall (combinational):
  - stall = ex_MemRead_int & (ex_dst == id_rs | ex_dst == id_rt) & ex_dst != 0.
  - While stall: pc_write=0, ifid_write=0, ID/EX loads a bubble, EX/MEM and MEM/WB advance normally.
  - Exactly one stall cycle per load-use pair.
- Jump flush: (id_Jump | id_PCSrc) & ~stall -> ifid_flush=1 for that cycle; the jump itself enters ID/EX normally.
- Branch flush: branch_taken=1 -> ifid_flush=1, ID/EX loads bubble, EX/MEM loads bubble; pc_write=ifid_write=1 (PC takes branch target).
- Priority:
  - branch_taken > stall > jump flush.
  - A stall coinciding with branch_taken is cancelled: the dependent instruction is squashed.
  - Jump coinciding with stall: no flush this cycle; the jump re-presents next cycle and flushes then.
- No cross-register combinational paths except stall/flush logic; all stage outputs come straight from flops.

Test Plan:
- Reset held 2 cycles with non-zero id_* inputs -> all ex_/mem_/wb_ outputs 0, pc_write=1, ifid_flush=0.
- R-type (RegDst=1, RegWrite=1, AluOp=5'b00010, rd=7) streamed -> ex_dst=7 at +1, mem_dst=7/mem_RegWrite=1 at +2, wb_dst=7/wb_RegWrite=1 at +3.
- lw to rt=4 followed by add reading rs=4 -> exactly one cycle pc_write=0, ifid_write=0, ex_* all 0 next edge; the add appears in EX one cycle later; lw with rt=0 -> no stall.
- jal in ID -> ifid_flush=1 one cycle, ex_dst=31, ex_RegSrc=1; wb_Jal=1 three cycles later.
- beq reaching MEM with branch_taken=1 while a load-use stall is active in ID -> ifid_flush=1, pc_write=1, next-edge ex_* and mem_* controls all 0, no stall.
- Assert reset while a sw is in EX/MEM -> mem_MemWrite=0 on the next edge, no further writes.
